// File: rtl/rst_gen_pkg.sv
// Shared definitions for the reset generator: FSM state encoding and the
// reset-cause codes reported on rst_cause.
package rst_gen_pkg;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;
  localparam logic [1:0] CAUSE_WDOG = 2'b11;

  // Arbitrates simultaneous reset requests: button beats watchdog beats soft.
  function automatic logic [1:0] sel_cause(input logic btn_req, input logic wdog_req);
    logic [1:0] cause;
    if (btn_req) begin
      cause = CAUSE_BTN;
    end else if (wdog_req) begin
      cause = CAUSE_WDOG;
    end else begin
      cause = CAUSE_SOFT;
    end
    return cause;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer for the active-low reset button;
// emits a single-cycle press pulse on each debounced high-to-low transition.
module btn_debounce #(
  parameter int DB_COUNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int DB_W = $clog2(DB_COUNT);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            btn_db_q;
  logic            btn_db_d;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            press_q;
  logic            press_d;

  // Count consecutive cycles of disagreement; any agreement restarts at zero.
  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    press_d = btn_db_q & ~btn_db_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      btn_db_q <= 1'b1;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/rst_gen_ctrl.sv
// System reset generator: stretches power-on, button, software and watchdog
// reset requests into a fixed-length registered active-low reset pulse.
module rst_gen_ctrl
  import rst_gen_pkg::*;
#(
  parameter int HOLD_COUNT = 1000,
  parameter int DB_COUNT   = 50000,
  parameter int WDOG_COUNT = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       soft_rst,
  input  logic       wdog_en,
  input  logic       wdog_kick,
  output logic       sys_rst_n,
  output logic [1:0] rst_cause
);

  localparam int HOLD_W = $clog2(HOLD_COUNT);
  localparam int WDOG_W = $clog2(WDOG_COUNT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_COUNT - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_COUNT - 1);

  state_e              state_q;
  state_e              state_d;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_d;
  logic [WDOG_W-1:0]   wdog_cnt_q;
  logic [WDOG_W-1:0]   wdog_cnt_d;
  logic                sys_rst_n_q;
  logic                sys_rst_n_d;
  logic [1:0]          rst_cause_q;
  logic [1:0]          rst_cause_d;
  logic                press;
  logic                wdog_exp;

  btn_debounce #(
    .DB_COUNT(DB_COUNT)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn_n(btn_n),
    .press(press)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    wdog_cnt_d  = '0;
    sys_rst_n_d = sys_rst_n_q;
    rst_cause_d = rst_cause_q;
    wdog_exp    = 1'b0;
    case (state_q)
      ST_HOLD: begin
        // Requests are deliberately ignored here so a hold is never extended.
        sys_rst_n_d = 1'b0;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d     = ST_RUN;
          hold_cnt_d  = '0;
          sys_rst_n_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        // A kick in the expiry cycle wins; the counter stops at its last value.
        if (wdog_en && !wdog_kick) begin
          if (wdog_cnt_q == WDOG_LAST) begin
            wdog_exp   = 1'b1;
            wdog_cnt_d = wdog_cnt_q;
          end else begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
          end
        end
        sys_rst_n_d = 1'b1;
        if (press || wdog_exp || soft_rst) begin
          state_d     = ST_HOLD;
          hold_cnt_d  = '0;
          wdog_cnt_d  = '0;
          sys_rst_n_d = 1'b0;
          rst_cause_d = sel_cause(press, wdog_exp);
        end
      end
      default: begin
        state_d     = ST_HOLD;
        hold_cnt_d  = '0;
        sys_rst_n_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      wdog_cnt_q  <= '0;
      sys_rst_n_q <= 1'b0;
      rst_cause_q <= CAUSE_POR;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      wdog_cnt_q  <= wdog_cnt_d;
      sys_rst_n_q <= sys_rst_n_d;
      rst_cause_q <= rst_cause_d;
    end
  end

  assign sys_rst_n = sys_rst_n_q;
  assign rst_cause = rst_cause_q;

endmodule

// File: tb/tb_rst_gen_ctrl.sv
// Directed bench for rst_gen_ctrl with HOLD_COUNT=8, DB_COUNT=4, WDOG_COUNT=20.
module tb_rst_gen_ctrl;

  localparam int HOLD = 8;
  localparam int DB   = 4;
  localparam int WD   = 20;

  logic       clk;
  logic       rst;
  logic       btn_n;
  logic       soft_rst;
  logic       wdog_en;
  logic       wdog_kick;
  logic       sys_rst_n;
  logic [1:0] rst_cause;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rst_gen_ctrl #(
    .HOLD_COUNT(HOLD),
    .DB_COUNT  (DB),
    .WDOG_COUNT(WD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .soft_rst (soft_rst),
    .wdog_en  (wdog_en),
    .wdog_kick(wdog_kick),
    .sys_rst_n(sys_rst_n),
    .rst_cause(rst_cause)
  );

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered at the negedge just after the edge that sampled the request.
  task automatic expect_hold(input string tag, input logic [1:0] cause,
                             input bit inject_soft, input int btn_rel_i);
    for (int i = 0; i < HOLD; i++) begin
      chk({tag, "_low"}, 2'(sys_rst_n), 2'd0);
      chk({tag, "_cause"}, rst_cause, cause);
      soft_rst = inject_soft && (i == 2);
      if (i == btn_rel_i) btn_n = 1'b1;
      tick(1);
    end
    soft_rst = 1'b0;
    chk({tag, "_rise"}, 2'(sys_rst_n), 2'd1);
    chk({tag, "_cause_run"}, rst_cause, cause);
  endtask

  task automatic expect_run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      chk({tag, "_high"}, 2'(sys_rst_n), 2'd1);
    end
  endtask

  // Entered at the negedge where rst was released.
  task automatic por_hold(input string tag);
    for (int i = 1; i < HOLD; i++) begin
      tick(1);
      chk({tag, "_low"}, 2'(sys_rst_n), 2'd0);
      chk({tag, "_cause"}, rst_cause, 2'b00);
    end
    tick(1);
    chk({tag, "_rise"}, 2'(sys_rst_n), 2'd1);
    chk({tag, "_cause_run"}, rst_cause, 2'b00);
  endtask

  initial begin
    rst       = 1'b0;
    btn_n     = 1'b1;
    soft_rst  = 1'b0;
    wdog_en   = 1'b0;
    wdog_kick = 1'b0;
    #1 rst = 1'b1;

    // Power-on
    tick(5);
    chk("in_rst_n", 2'(sys_rst_n), 2'd0);
    chk("in_rst_cause", rst_cause, 2'b00);
    rst = 1'b0;
    por_hold("por");

    // Software reset, with a second request during the hold
    soft_rst = 1'b1;
    tick(1);
    expect_hold("soft", 2'b10, 1'b1, -1);

    // Bouncing button: 3 low, 1 high, then held low for 10 cycles
    btn_n = 1'b0;
    expect_run("bnc_a", 3);
    btn_n = 1'b1;
    expect_run("bnc_b", 1);
    btn_n = 1'b0;
    expect_run("bnc_wait", 6);
    tick(1);
    expect_hold("btn", 2'b01, 1'b0, 3);
    expect_run("bnc_single", 15);

    // Watchdog expiry with no kicks
    wdog_en = 1'b1;
    expect_run("wd_count", WD - 1);
    tick(1);
    expect_hold("wdog", 2'b11, 1'b0, -1);

    // Regular kicks keep the system running
    for (int i = 0; i < 200; i++) begin
      wdog_kick = (i % 15 == 14);
      tick(1);
      chk("wd_kick_high", 2'(sys_rst_n), 2'd1);
    end
    wdog_kick = 1'b0;
    wdog_en   = 1'b0;

    soft_rst = 1'b1;
    tick(1);
    expect_hold("soft2", 2'b10, 1'b0, -1);

    // Press event, expiry and soft request all sampled on the same edge
    wdog_en = 1'b1;
    expect_run("sim_a", 13);
    btn_n = 1'b0;
    expect_run("sim_b", 6);
    soft_rst = 1'b1;
    tick(1);
    expect_hold("sim3", 2'b01, 1'b0, 3);

    // Expiry plus soft request on the same edge
    expect_run("sim_c", WD - 1);
    soft_rst = 1'b1;
    tick(1);
    expect_hold("wdsoft", 2'b11, 1'b0, -1);

    // rst asserted at hold count 5
    wdog_en  = 1'b0;
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    tick(5);
    chk("mid_pre_low", 2'(sys_rst_n), 2'd0);
    chk("mid_pre_cause", rst_cause, 2'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst_low", 2'(sys_rst_n), 2'd0);
    chk("mid_rst_cause", rst_cause, 2'b00);
    tick(2);
    rst = 1'b0;
    por_hold("mid_hold");

    // rst asserted while running
    rst = 1'b1;
    #1;
    chk("run_rst_low", 2'(sys_rst_n), 2'd0);
    tick(1);
    rst = 1'b0;
    por_hold("run_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
